// File: rtl/audio_sdm_dac_pkg.sv
// Shared constants for the audio output stage: default widths, divider ratio
// and the half-scale / integrator-width helpers used by the modulator.
package audio_pkg;

  localparam int SAMPLE_BITS_DEF = 12;
  localparam int CLK_DIV_DEF     = 64;
  localparam int SLEW_DEF        = 64;
  localparam int INT_EXTRA_BITS  = 4;

  function automatic int half_scale(input int bits);
    return 1 << (bits - 1);
  endfunction

  function automatic int int_width(input int bits);
    return bits + INT_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/audio_sdm_dac_sdm_modulator.sv
// Sigma-delta modulator turning a signed level into a 1-bit stream.
// First order by default; AUDIO_SDM_ORDER2_EN selects a saturating second-order loop.
module sdm_modulator
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic signed [SAMPLE_BITS-1:0] level,
  output logic                          pdm_bit
);

`ifdef AUDIO_SDM_ORDER2_EN
  localparam int IW = int_width(SAMPLE_BITS);
  localparam int SW = IW + 2;
  localparam logic signed [SW-1:0] FB_POS = SW'(half_scale(SAMPLE_BITS));
  localparam logic signed [SW-1:0] FB_NEG = -FB_POS;
  localparam logic signed [SW-1:0] I_MAX  = SW'((1 << (IW - 1)) - 1);
  localparam logic signed [SW-1:0] I_MIN  = -I_MAX - SW'(1);

  logic signed [IW-1:0] i1, i2, i1_nxt, i2_nxt;
  logic signed [SW-1:0] fb, i1_sum, i2_sum;

  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] x);
    if (x > I_MAX) return IW'(I_MAX);
    if (x < I_MIN) return IW'(I_MIN);
    return IW'(x);
  endfunction

  // Integrators are widened by two bits before the clamp so overflow is visible.
  always_comb begin
    fb     = pdm_bit ? FB_POS : FB_NEG;
    i1_sum = SW'(i1) + SW'(level) - fb;
    i1_nxt = sat(i1_sum);
    i2_sum = SW'(i2) + SW'(i1_nxt) - fb;
    i2_nxt = sat(i2_sum);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i1      <= '0;
      i2      <= '0;
      pdm_bit <= 1'b0;
    end else begin
      i1      <= i1_nxt;
      i2      <= i2_nxt;
      pdm_bit <= ~i2_nxt[IW-1];
    end
  end
`else
  logic [SAMPLE_BITS-1:0] acc, u;
  logic [SAMPLE_BITS:0]   sum;

  // Offset binary: flipping the sign bit adds half scale.
  assign u   = {~level[SAMPLE_BITS-1], level[SAMPLE_BITS-2:0]};
  assign sum = {1'b0, acc} + {1'b0, u};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      pdm_bit <= 1'b0;
    end else begin
      acc     <= sum[SAMPLE_BITS-1:0];
      pdm_bit <= sum[SAMPLE_BITS];
    end
  end
`endif

endmodule

// File: rtl/audio_sdm_dac.sv
// Audio output stage: sample-rate divider, per-period capture with slew limiting,
// and the sigma-delta modulator (AUDIO_SDM_ORDER2_EN selects second order).
module audio_sdm_dac
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int SLEW        = SLEW_DEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  output logic                          sample_clk,
  input  logic signed [SAMPLE_BITS-1:0] in,
  input  logic                          mute,
  output logic                          dac_out
);

  localparam int DW    = $clog2(CLK_DIV);
  localparam int DIFFW = SAMPLE_BITS + 2;
  localparam logic signed [DIFFW-1:0] SLEW_P = DIFFW'(SLEW);
  localparam logic signed [DIFFW-1:0] SLEW_N = -SLEW_P;

  logic [DW-1:0]                 div_cnt, div_nxt;
  logic                          capture;
  logic signed [SAMPLE_BITS-1:0] level, target;
  logic signed [DIFFW-1:0]       d, step;

  assign div_nxt = (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
  assign capture = (div_cnt == DW'(CLK_DIV / 2 - 1));

  // Step is bounded by |target - level|, so the new level never leaves range.
  always_comb begin
    target = mute ? '0 : in;
    d      = DIFFW'(target) - DIFFW'(level);
    if (d > SLEW_P)      step = SLEW_P;
    else if (d < SLEW_N) step = SLEW_N;
    else                 step = d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt    <= '0;
      sample_clk <= 1'b0;
      level      <= '0;
    end else begin
      div_cnt    <= div_nxt;
      sample_clk <= (div_nxt < DW'(CLK_DIV / 2));
      if (capture)
        level <= level + SAMPLE_BITS'(step);
    end
  end

  sdm_modulator #(
    .SAMPLE_BITS(SAMPLE_BITS)
  ) u_mod (
    .clk    (clk),
    .resetn (resetn),
    .level  (level),
    .pdm_bit(dac_out)
  );

endmodule

// File: tb/tb_audio_sdm_dac.sv
// Directed bench for audio_sdm_dac: divider model, level ramp scoreboard and
// bitstream density windows.
module tb_audio_sdm_dac;

  localparam int SB    = 12;
  localparam int CD    = 64;
  localparam int SL    = 64;
  localparam int HALFP = CD / 2;
  localparam int WIN   = 4096;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 sample_clk;
  logic                 mute = 1'b0;
  logic                 dac_out;
  logic signed [SB-1:0] in_s = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int mdiv     = 0;
  int lvl_model = 0;
  int lvl_tail  = 0;
  int exp_q[$];
  int ones;

  audio_sdm_dac #(
    .SAMPLE_BITS(SB),
    .CLK_DIV    (CD),
    .SLEW       (SL)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sample_clk(sample_clk),
    .in        (in_s),
    .mute      (mute),
    .dac_out   (dac_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ramp_step(input int from, input int to);
    int d;
    d = to - from;
    if (d > SL)  return from + SL;
    if (d < -SL) return from - SL;
    return to;
  endfunction

  // Expected level after each future capture, computed when the target changes.
  task automatic push_target(input int t);
    while (lvl_tail != t) begin
      lvl_tail = ramp_step(lvl_tail, t);
      exp_q.push_back(lvl_tail);
    end
  endtask

  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    mdiv = (mdiv + 1) % CD;
    check("sample_clk", sample_clk, (mdiv < HALFP));
    if (mdiv == HALFP) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : lvl_model;
      lvl_model = e;
      check("level_capture", dut.level, e);
    end else begin
      check("level_hold", dut.level, lvl_model);
    end
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("settle_pending", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic count_ones(input int n);
    ones = 0;
    repeat (n) begin
      tick();
      ones += int'(dac_out);
    end
  endtask

  task automatic wait_div(input int v);
    int n;
    n = 0;
    while (mdiv != v && n < 2 * CD) begin
      tick();
      n++;
    end
    check("wait_div", mdiv, v);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample_clk", sample_clk, 0);
    check("rst_dac_out", dac_out, 0);
    check("rst_level", dut.level, 0);

    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
`ifndef AUDIO_SDM_ORDER2_EN
      check("dac_alternate", dac_out, (k % 2 == 0));
`endif
    end
    repeat (2 * CD - 16) tick();

    in_s = 12'sd1000;
    push_target(1000);
    settle(20 * CD);
    count_ones(WIN);
`ifdef AUDIO_SDM_ORDER2_EN
    check("density_1000_o2", (ones >= 3046 && ones <= 3050), 1);
`else
    check("density_1000", ones, 3048);
`endif

    // Mute pulse entirely between captures must not move the level.
    wait_div(40);
    mute = 1'b1;
    repeat (10) tick();
    mute = 1'b0;
    repeat (CD) tick();

    wait_div(10);
    mute = 1'b1;
    push_target(0);
    settle(20 * CD);
    check("muted_level", dut.level, 0);
    mute = 1'b0;
    push_target(1000);
    settle(20 * CD);
    check("unmuted_level", dut.level, 1000);

`ifndef AUDIO_SDM_ORDER2_EN
    in_s = -12'sd2048;
    push_target(-2048);
    settle(60 * CD);
    count_ones(WIN);
    check("density_min", ones, 0);

    in_s = 12'sd2047;
    push_target(2047);
    settle(80 * CD);
    count_ones(WIN);
    check("density_max", ones, WIN - 1);
`endif

    in_s = 12'sd500;
    push_target(500);
    settle(80 * CD);
    check("level_500", dut.level, 500);

    wait_div(20);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("async_rst_sample_clk", sample_clk, 0);
    check("async_rst_dac_out", dac_out, 0);
    check("async_rst_level", dut.level, 0);
    check("async_rst_div", dut.div_cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    mdiv = 0;
    lvl_model = 0;
    lvl_tail = 0;
    exp_q.delete();
    push_target(500);
    for (int k = 1; k <= 4; k++) begin
      tick();
`ifndef AUDIO_SDM_ORDER2_EN
      check("post_rst_alternate", dac_out, (k % 2 == 0));
`endif
    end
    settle(20 * CD);
    check("post_rst_level", dut.level, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
